// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the scan-capable channel multiplexer.
//   mode_e    : static (sel-driven) or scan (internal round-robin) selection
//   tag_t     : channel tag carried alongside each output sample {ch, oor}
//   sel_width : select width for a given channel count, never below 1
package mux_scan_pkg;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Tag channel field is sized for up to 256 channels; users truncate to SEL_W.
    localparam int unsigned TAG_CH_W = 8;

    typedef struct packed {
        logic [TAG_CH_W-1:0] ch;
        logic                oor;
    } tag_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Scan-mode channel counter: advances the channel every DWELL accepted beats.
//   clk, rst_n : clock, async active-low reset
//   mode       : static mode holds both counters at zero
//   adv        : one accepted beat
//   ch         : current scan channel
module mux_scan_ctr
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DWELL = 1,
    parameter int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             adv,
    output logic [SEL_W-1:0] ch
);

    localparam int unsigned DW_W = sel_width(DWELL);
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] ch_cnt;
    logic [DW_W-1:0]  dwell_cnt;

    // Static mode parks the counters so a scan always starts from channel 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (mode == MODE_STATIC) begin
            ch_cnt    <= '0;
            dwell_cnt <= '0;
        end else if (adv) begin
            if (dwell_cnt == DW_LAST) begin
                dwell_cnt <= '0;
                ch_cnt    <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + SEL_W'(1);
            end else begin
                dwell_cnt <= dwell_cnt + DW_W'(1);
            end
        end
    end

    assign ch = ch_cnt;

endmodule

// File: rtl/mux_scan_pipe.sv
// Registered N_CH:1 multiplexer with valid/ready output and round-robin scan mode.
// Optional macro MUX_SCAN_PIPE_SKID_EN adds a one-entry skid register so that
// in_ready has no combinational path from y_ready.
//   clk, rst_n          : clock, async active-low reset
//   d                   : N_CH packed channels, channel k at d[k*W +: W]
//   sel, mode           : static select / scan enable
//   in_valid, in_ready  : input handshake
//   y, y_ch, y_oor      : selected data, source channel, out-of-range flag
//   y_valid, y_ready    : output handshake
module mux_scan_pipe
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 1,
    localparam int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  y_ch,
    output logic              y_oor,
    output logic              y_valid,
    input  logic              y_ready
);

    logic             accept;
    logic [SEL_W-1:0] scan_ch;
    logic [SEL_W-1:0] cur_ch;
    logic             sel_oor;
    logic [W-1:0]     mux_y;
    tag_t             new_tag;
    logic [W-1:0]     y_q;
    tag_t             out_tag;
    logic             unused_tag;

    mux_scan_ctr #(
        .N_CH  (N_CH),
        .DWELL (DWELL),
        .SEL_W (SEL_W)
    ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .adv   (accept),
        .ch    (scan_ch)
    );

    // Channel select and mux; an out-of-range sel matches no channel and yields 0.
    always_comb begin
        cur_ch  = (mode == MODE_SCAN) ? scan_ch : sel;
        sel_oor = (mode == MODE_STATIC) && ({1'b0, sel} >= (SEL_W+1)'(N_CH));
        mux_y   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                mux_y = d[k*W +: W];
            end
        end
        new_tag.ch  = TAG_CH_W'(cur_ch);
        new_tag.oor = sel_oor;
    end

    assign accept = in_valid & in_ready;

`ifdef MUX_SCAN_PIPE_SKID_EN
    logic [W-1:0] skid_y;
    tag_t         skid_tag;
    logic         skid_full;

    // in_ready depends only on the skid flop, breaking the path from y_ready.
    assign in_ready = ~skid_full;

    // Output register backed by a skid entry that catches the sample accepted under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= '0;
            out_tag   <= '0;
            y_valid   <= 1'b0;
            skid_y    <= '0;
            skid_tag  <= '0;
            skid_full <= 1'b0;
        end else if (y_valid && y_ready) begin
            if (skid_full) begin
                y_q       <= skid_y;
                out_tag   <= skid_tag;
                skid_full <= 1'b0;
            end else if (accept) begin
                y_q     <= mux_y;
                out_tag <= new_tag;
            end else begin
                y_valid <= 1'b0;
            end
        end else if (!y_valid) begin
            if (accept) begin
                y_q     <= mux_y;
                out_tag <= new_tag;
                y_valid <= 1'b1;
            end
        end else if (accept) begin
            skid_y    <= mux_y;
            skid_tag  <= new_tag;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = ~y_valid | y_ready;

    // Single output register: load on accept, drop valid after an unreplaced beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            out_tag <= '0;
            y_valid <= 1'b0;
        end else if (accept) begin
            y_q     <= mux_y;
            out_tag <= new_tag;
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end
`endif

    assign y          = y_q;
    assign y_ch       = SEL_W'(out_tag.ch);
    assign y_oor      = out_tag.oor;
    assign unused_tag = ^(out_tag.ch >> SEL_W);

endmodule

// File: tb/tb_mux_scan_pipe.sv
// Directed self-checking bench for mux_scan_pipe, three parameterisations:
//   u_a : N_CH=4, W=1, DWELL=1   static select
//   u_b : N_CH=3, W=8, DWELL=1   out-of-range select
//   u_c : N_CH=4, W=8, DWELL=2   scan, stall, mode toggle, async reset
module tb_mux_scan_pipe;

    logic clk;
    logic rst_n;

    logic [3:0]  a_d;
    logic [1:0]  a_sel, a_y_ch;
    logic        a_mode, a_in_valid, a_in_ready, a_y, a_y_oor, a_y_valid, a_y_ready;

    logic [23:0] b_d;
    logic [1:0]  b_sel, b_y_ch;
    logic [7:0]  b_y;
    logic        b_mode, b_in_valid, b_in_ready, b_y_oor, b_y_valid, b_y_ready;

    logic [31:0] c_d;
    logic [1:0]  c_sel, c_y_ch;
    logic [7:0]  c_y;
    logic        c_mode, c_in_valid, c_in_ready, c_y_oor, c_y_valid, c_y_ready;

    int n_cmp;
    int n_err;

    mux_scan_pipe #(.N_CH(4), .W(1), .DWELL(1)) u_a (
        .clk(clk), .rst_n(rst_n), .d(a_d), .sel(a_sel), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .y(a_y), .y_ch(a_y_ch),
        .y_oor(a_y_oor), .y_valid(a_y_valid), .y_ready(a_y_ready)
    );

    mux_scan_pipe #(.N_CH(3), .W(8), .DWELL(1)) u_b (
        .clk(clk), .rst_n(rst_n), .d(b_d), .sel(b_sel), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .y(b_y), .y_ch(b_y_ch),
        .y_oor(b_y_oor), .y_valid(b_y_valid), .y_ready(b_y_ready)
    );

    mux_scan_pipe #(.N_CH(4), .W(8), .DWELL(2)) u_c (
        .clk(clk), .rst_n(rst_n), .d(c_d), .sel(c_sel), .mode(c_mode),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .y(c_y), .y_ch(c_y_ch),
        .y_oor(c_y_oor), .y_valid(c_y_valid), .y_ready(c_y_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [3:0] a_pat;
        logic [1:0] scan_seq [9];
        logic [1:0] beat_ch  [16];
        logic [7:0] beat_y   [16];
        int         n_beat;
        int         n_acc;
        logic       pre_stall;
        logic [7:0] pre_y;
        logic [1:0] pre_ch;

        n_cmp = 0;
        n_err = 0;
        scan_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        rst_n = 1'b0;
        a_d = '0; a_sel = '0; a_mode = 1'b0; a_in_valid = 1'b0; a_y_ready = 1'b0;
        b_d = '0; b_sel = '0; b_mode = 1'b0; b_in_valid = 1'b0; b_y_ready = 1'b0;
        c_d = '0; c_sel = '0; c_mode = 1'b0; c_in_valid = 1'b0; c_y_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_a_valid", 32'(a_y_valid), 0);
        chk("rst_a_y",     32'(a_y), 0);
        chk("rst_b_y",     32'(b_y), 0);
        chk("rst_c_ch",    32'(c_y_ch), 0);
        chk("rst_c_oor",   32'(c_y_oor), 0);
        rst_n = 1'b1;
        tick();

        // Static 4:1, W=1: d=0110 gives 0,1,1,0 for sel 0..3
        a_pat      = 4'b0110;
        a_d        = a_pat;
        a_y_ready  = 1'b1;
        a_in_valid = 1'b1;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            tick();
            chk("a_y",     32'(a_y), 32'(a_pat[s]));
            chk("a_ch",    32'(a_y_ch), 32'(s));
            chk("a_valid", 32'(a_y_valid), 1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("a_drop_valid", 32'(a_y_valid), 0);

        // N_CH=3: out-of-range sel, then in-range
        b_d        = {8'hA5, 8'h3C, 8'h7E};
        b_y_ready  = 1'b1;
        b_in_valid = 1'b1;
        b_sel      = 2'd3;
        tick();
        chk("b_oor_y",   32'(b_y), 0);
        chk("b_oor_ch",  32'(b_y_ch), 3);
        chk("b_oor_flag", 32'(b_y_oor), 1);
        b_sel = 2'd2;
        tick();
        chk("b_y2",    32'(b_y), 32'h A5);
        chk("b_oor2",  32'(b_y_oor), 0);
        b_sel = 2'd0;
        tick();
        chk("b_y0",    32'(b_y), 32'h7E);
        b_in_valid = 1'b0;

        // Scan with DWELL=2, no backpressure
        c_d        = {8'h44, 8'h33, 8'h22, 8'h11};
        c_mode     = 1'b1;
        c_y_ready  = 1'b1;
        c_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("scan_ch",  32'(c_y_ch), 32'(scan_seq[i]));
            chk("scan_y",   32'(c_y), 32'(8'h11) * (32'(scan_seq[i]) + 1));
            chk("scan_oor", 32'(c_y_oor), 0);
        end
        c_in_valid = 1'b0;
        tick();
        chk("scan_idle_valid", 32'(c_y_valid), 0);

        // Scan with y_ready low for 3 cycles mid-stream
        c_mode = 1'b0;
        tick();
        c_mode = 1'b1;
        n_beat = 0;
        n_acc  = 0;
        for (int i = 0; i < 40 && n_beat < 9; i++) begin
            c_y_ready  = !(i >= 3 && i < 6);
            c_in_valid = (n_acc < 9);
            #1;
`ifdef MUX_SCAN_PIPE_SKID_EN
            if (i == 3) chk("skid_rdy_first_stall", 32'(c_in_ready), 1);
            if (i == 4) chk("skid_rdy_full", 32'(c_in_ready), 0);
`else
            if (i == 3) chk("rdy_stall", 32'(c_in_ready), 0);
            if (i == 6) chk("rdy_resume", 32'(c_in_ready), 1);
`endif
            pre_stall = c_y_valid && !c_y_ready;
            pre_y     = c_y;
            pre_ch    = c_y_ch;
            if (c_y_valid && c_y_ready) begin
                beat_ch[n_beat] = c_y_ch;
                beat_y[n_beat]  = c_y;
                n_beat++;
            end
            if (c_in_valid && c_in_ready) n_acc++;
            tick();
            if (pre_stall) begin
                chk("hold_y",  32'(c_y), 32'(pre_y));
                chk("hold_ch", 32'(c_y_ch), 32'(pre_ch));
                chk("hold_valid", 32'(c_y_valid), 1);
            end
        end
        chk("stall_beats", 32'(n_beat), 9);
        chk("stall_accepts", 32'(n_acc), 9);
        for (int k = 0; k < 9 && k < n_beat; k++) begin
            chk("stall_seq_ch", 32'(beat_ch[k]), 32'(scan_seq[k]));
            chk("stall_seq_y",  32'(beat_y[k]), 32'(8'h11) * (32'(scan_seq[k]) + 1));
        end
        c_in_valid = 1'b0;
        c_y_ready  = 1'b1;
        tick();
        tick();

        // Mode toggle mid-scan restarts at channel 0
        c_mode = 1'b0;
        tick();
        c_mode     = 1'b1;
        c_in_valid = 1'b1;
        repeat (4) tick();
        chk("toggle_pre_ch", 32'(c_y_ch), 1);
        c_in_valid = 1'b0;
        c_mode     = 1'b0;
        tick();
        c_mode = 1'b1;
        tick();
        c_in_valid = 1'b1;
        tick();
        chk("toggle_ch", 32'(c_y_ch), 0);
        chk("toggle_y",  32'(c_y), 32'h11);
        c_in_valid = 1'b0;
        tick();

        // Async reset while stalled with valid data, counters mid-scan
        c_mode = 1'b0;
        tick();
        c_mode     = 1'b1;
        c_in_valid = 1'b1;
        c_y_ready  = 1'b1;
        repeat (3) tick();
        c_in_valid = 1'b0;
        c_y_ready  = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(c_y_valid), 1);
        chk("pre_rst_y",     32'(c_y), 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(c_y_valid), 0);
        chk("arst_y",     32'(c_y), 0);
        chk("arst_ch",    32'(c_y_ch), 0);
        #1;
        rst_n = 1'b0;
        #1;
        rst_n      = 1'b1;
        c_mode     = 1'b1;
        c_in_valid = 1'b1;
        c_y_ready  = 1'b1;
        tick();
        chk("post_rst_ch", 32'(c_y_ch), 0);
        chk("post_rst_y",  32'(c_y), 32'h11);
        c_in_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
